// File: rtl/indirect_bank_sequencer_if.sv
// rtl/indirect_bank_sequencer_if.sv - CPU-side bus and bank signals of the indirect bank sequencer
interface indirect_bank_sequencer_if #(
    parameter int BANK_W = 4
);
    logic              cycle_end;
    logic              sync;
    logic              rdy;
    logic              r_w;
    logic [7:0]        data_cpu;
    logic [BANK_W-1:0] exec_bank;
    logic [BANK_W-1:0] ind_bank;
    logic [BANK_W-1:0] address_bank;
    logic              sel_ind;
    logic [2:0]        seq_state;

    modport master (
        output cycle_end, sync, rdy, r_w, data_cpu, exec_bank, ind_bank,
        input  address_bank, sel_ind, seq_state
    );

    modport slave (
        input  cycle_end, sync, rdy, r_w, data_cpu, exec_bank, ind_bank,
        output address_bank, sel_ind, seq_state
    );
endinterface

// File: rtl/indirect_bank_sequencer.sv
// rtl/indirect_bank_sequencer.sv - per-bus-cycle 6509 bank select for (zp),Y loads and stores
module indirect_bank_sequencer #(
    parameter int                BANK_W     = 4,
    parameter logic [7:0]        OPC_MASK   = 8'hDF,
    parameter logic [7:0]        OPC_MATCH  = 8'h91,
    parameter logic [BANK_W-1:0] RESET_BANK = 4'hF
) (
    input logic                    clock,
    input logic                    reset,
    indirect_bank_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OPER = 3'd1,
        PTRL = 3'd2,
        PTRH = 3'd3,
        EA1  = 3'd4,
        EA2  = 3'd5
    } state_t;

    state_t state;
    state_t state_next;
    logic   sel_q;
    logic   sel_next;
    logic   started;
    logic   adv;
    logic   opc_hit;
    logic   sel_live;

    // RDY only stalls reads, so a write cycle always advances the sequence
    assign adv     = bus.cycle_end & (bus.rdy | ~bus.r_w);
    assign opc_hit = bus.sync & ((bus.data_cpu & OPC_MASK) == OPC_MATCH);

    // Next state: any opcode fetch re-decodes (new instruction, back-to-back or abort)
    always_comb begin
        state_next = state;
        if (bus.sync) begin
            state_next = opc_hit ? OPER : IDLE;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                OPER:    state_next = PTRL;
                PTRL:    state_next = PTRH;
                PTRH:    state_next = EA1;
                EA1:     state_next = EA2;
                EA2:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        sel_next = (state_next == EA1) || (state_next == EA2);
    end

    // State and registered bank select, both describing the next bus cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel_q <= 1'b0;
        end else if (adv) begin
            state <= state_next;
            sel_q <= sel_next;
        end
    end

    // Hold address_bank at RESET_BANK until the first bus cycle after reset completes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            started <= 1'b0;
        end else if (bus.cycle_end) begin
            started <= 1'b1;
        end
    end

    // An EA2 slot that turns out to be an opcode fetch (LDA without page cross)
    // must revert to the execution bank; this is the only combinational path.
    assign sel_live = sel_q & ~((state == EA2) & bus.sync);

    assign bus.sel_ind      = sel_live;
    assign bus.seq_state    = state;
    assign bus.address_bank = !started ? RESET_BANK :
                              (sel_live ? bus.ind_bank : bus.exec_bank);

endmodule
